device_bus_arbiter: RTL

//  Shares the single 32-bit memory-mapped device bus between MASTERS requesters (CPU, DMA, debug).

---
 rtl/bus_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/device_bus_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared widths, arbiter state encoding and index-width helper for the device bus slice.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arb_state_t;

  // Index width that stays at least 1 bit so a single-requester build still elaborates.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request found scanning upward from last+1 with wrap.
module rr_picker
  import bus_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] winner
);

  int unsigned idx;
  logic        found;

  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[idx[IW-1:0]]) begin
        winner = idx[IW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/device_bus_arbiter.sv
// Round-robin owner of the shared device bus: one registered access at a time,
// watchdog abort on unacknowledged strobes, per-master done/error pulses.
module device_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MASTERS-1:0]      m_req,
  input  logic [MASTERS-1:0]      m_wr,
  input  logic [MASTERS*32-1:0]   m_addr,
  input  logic [MASTERS*32-1:0]   m_wdata,
  output logic [MASTERS-1:0]      m_done,
  output logic [MASTERS-1:0]      m_err,
  output logic [31:0]             m_rdata,
  output logic [MASTERS-1:0]      grant,
  output logic [31:0]             bus_addr,
  output logic [31:0]             bus_wdata,
  output logic                    bus_wr,
  output logic                    bus_rd,
  input  logic                    bus_ack,
  input  logic [31:0]             bus_rdata
);

  localparam int unsigned IW = idx_w(MASTERS);
  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_RST  = IW'(MASTERS - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  arb_state_t state, state_next;

  logic [IW-1:0]         last;
  logic [IW-1:0]         winner;
  logic                  any;
  logic [WW-1:0]         wdog;
  logic                  start, finish_ok, finish_to;
  logic [MASTERS-1:0]    win_oh, owner_oh;
  logic [BUS_ADDR_W-1:0] win_addr;
  logic [BUS_DATA_W-1:0] win_wdata;
  logic                  win_wr;

  rr_picker #(.N(MASTERS)) u_picker (
    .req    (m_req),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  // Winner's request fields and one-hot decodes; during ACCESS 'last' is the owner.
  always_comb begin
    win_oh    = '0;
    owner_oh  = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_wr    = 1'b0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      owner_oh[i] = (last == IW'(i));
      if (winner == IW'(i)) begin
        win_oh[i] = 1'b1;
        win_addr  = m_addr[i*BUS_ADDR_W +: BUS_ADDR_W];
        win_wdata = m_wdata[i*BUS_DATA_W +: BUS_DATA_W];
        win_wr    = m_wr[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:   if (any) state_next = ARB_ACCESS;
      ARB_ACCESS: if (bus_ack || wdog == WDOG_LAST) state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // Ack is tested first so an ack in the final watchdog cycle completes normally.
  always_comb begin
    start     = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    unique case (state)
      ARB_IDLE:   start = any;
      ARB_ACCESS: begin
        finish_ok = bus_ack;
        finish_to = !bus_ack && (wdog == WDOG_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      m_done    <= '0;
      m_err     <= '0;
      m_rdata   <= '0;
      last      <= LAST_RST;
      wdog      <= '0;
    end else begin
      m_done <= '0;
      m_err  <= '0;
      if (start) begin
        grant     <= win_oh;
        bus_addr  <= win_addr;
        bus_wdata <= win_wdata;
        bus_wr    <= win_wr;
        bus_rd    <= !win_wr;
        last      <= winner;
        wdog      <= '0;
      end else if (finish_ok) begin
        m_done <= owner_oh;
        if (bus_rd) m_rdata <= bus_rdata;
        grant  <= '0;
        bus_wr <= 1'b0;
        bus_rd <= 1'b0;
      end else if (finish_to) begin
        m_err  <= owner_oh;
        grant  <= '0;
        bus_wr <= 1'b0;
        bus_rd <= 1'b0;
      end else if (state == ARB_ACCESS) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

endmodule
